seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexes one shared 7-segment hex decoder across NDIGITS common-anode digits. It holds a double-buffered display word and steps a digit index at a prescaled rate. On each step it drives the selected nibble into the decoder and asserts the matching digit enable, with an all-off guard interval between digits to prevent ghosting. It sits between the application logic, which loads values through a valid/ready handshake, and the board's segment and digit pins.

Parameters:
NDIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clk cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2, cycles per slot with all digit enables off (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
value_in  input  4*NDIGITS  hex digits; nibble i drives digit i; digit 0 is least significant
dp_in  input  NDIGITS  decimal point request per digit, active-high
load_valid  input  1  value_in/dp_in valid
load_ready  output  1  block can accept a load
lzb_en  input  1  leading-zero blanking enable
leds  output  8  segment drive, active-low; bit 7 is the decimal point
ct  output  NDIGITS  digit enables, active-high, one-hot or zero
frame_done  output  1  one-cycle pulse after the last digit slot of a frame

Behaviour:
- Reset (async assert, sync release):
  - leds=8'hFF, ct=0, frame_done=0, load_ready=1.
  - Active and shadow registers = 0; pending=0; idx=0; cnt=0; state=BLANK.
- Slot counter cnt runs 0..PRESCALE-1, then wraps to 0 and increments idx. idx wraps from NDIGITS-1 to 0.
- FSM:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt >= BLANK_CYCLES.
  - BLANK->SHOW when cnt == BLANK_CYCLES-1.
  - SHOW->BLANK when cnt == PRESCALE-1.
- All outputs are registered. ct/leds reflect the state one cycle after the FSM enters it.
  - BLANK: ct=0, leds=8'hFF.
  - SHOW: ct = one-hot(idx), unless the digit is blanked. leds[6:0] = decode of active nibble idx. leds[7] = ~active_dp[idx].
- Segment encoding, active-low, bits [6:0]=g..a: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, bit 7 excluded).
- Leading-zero blanking: when lzb_en=1, digit i (i>0) is blanked if all active nibbles i..NDIGITS-1 are 0.
  - Blanked digit: ct stays 0 for the slot, leds=8'hFF.
  - Digit 0 is never blanked.
  - A set dp bit does not prevent blanking.
- Handshake:
  - Accept when load_valid & load_ready. Capture value_in/dp_in into shadow; set pending.
  - load_ready = ~pending.
- Frame boundary (cnt==PRESCALE-1 and idx==NDIGITS-1):
  - frame_done pulses high the following cycle.
  - If pending: active<=shadow, pending<=0, load_ready high from the next cycle.
- Loads never tear a frame; a new value first appears in the slot for digit 0.
- Load accepted on the boundary cycle itself (pending was 0): applied at the next boundary.
- load_valid held while load_ready=0: no effect; the data is not captured until ready.
- Reset mid-slot: outputs go to reset values immediately; scanning resumes at digit 0 in BLANK.
- lzb_en is sampled combinationally each SHOW cycle; a change takes effect within one cycle.

Decomposition:
- Shared package seg7_pkg:
  - Segment-code constants SEG_0..SEG_F and SEG_OFF=8'hFF.
  - typedef enum logic {BLANK, SHOW} scan_state_t.
  - Helper function for the one-hot digit mask.
- One sub-module: seg7_hex_decode (combinational nibble->7-segment map). It is instantiated once and fed by the idx-selected nibble.

Test Plan:
(All with NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2.)
1. Reset, then load 16'h1234, dp=0, lzb_en=0 -> after the next frame boundary, slots show ct=0001 leds=F9... wait, digit 0 = nibble 4 -> ct=0001/leds=8'h99; 0010/8'hB0; 0100/8'hA4; 1000/8'hF9. Each slot has 2 cycles ct=0 then 6 cycles asserted; frame_done pulses every 32 cycles.
2. Load 16'h00A0, lzb_en=1 -> digit0 ct=0001/8'hC0, digit1 ct=0010/8'h88, digits 2 and 3 ct=0 with leds=8'hFF; with lzb_en=0 the same value shows digits 2/3 as 8'hC0.
3. dp_in=4'b0100 with value 16'h8888 -> digit 2 slot shows leds=8'h00; other slots show 8'h80.
4. Load mid-frame -> load_ready drops the cycle after acceptance. A second load_valid is ignored. New data appears at digit 0 of the next frame; load_ready returns high the cycle after the boundary.
5. load_valid asserted on the boundary cycle with pending=0 -> data captured but not shown in the frame starting now; shown in the following frame.
6. Assert reset for 1 cycle during a SHOW slot of digit 2 -> ct=0 and leds=8'hFF asynchronously; after release, first enable is ct=0001 at cycle 3; shown value = 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// active-low segment codes (bits [6:0] = g..a), the scan FSM state type,
// and the one-hot digit-enable helper.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments and the decimal point dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // One-hot enable for digit idx; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble - hex digit to display
//   seg_c  - segment drive, active-low, bits [6:0] = g..a
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NDIGITS common-anode 7-segment digits.
// A double-buffered display word is loaded through a valid/ready handshake and
// swapped in only at frame boundaries, so a frame is never torn. Each digit
// slot lasts PRESCALE cycles, the first BLANK_CYCLES of which keep all digit
// enables off to avoid ghosting.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   value_in    - 4*NDIGITS hex digits, nibble i drives digit i
//   dp_in       - per-digit decimal point request, active-high
//   load_valid  - value_in/dp_in valid
//   load_ready  - block can accept a load (low while a load is pending)
//   lzb_en      - leading-zero blanking enable
//   leds        - segment drive, active-low, bit 7 is the decimal point
//   ct          - digit enables, active-high, one-hot or zero
//   frame_done  - one-cycle pulse after the last digit slot of a frame
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NDIGITS-1:0] value_in,
  input  logic [NDIGITS-1:0]   dp_in,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic                 lzb_en,
  output logic [7:0]           leds,
  output logic [NDIGITS-1:0]   ct,
  output logic                 frame_done
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = $clog2(NDIGITS);
  localparam int unsigned VW = 4 * NDIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  scan_state_t        state;
  scan_state_t        next_state;

  logic [VW-1:0]      active_val;
  logic [NDIGITS-1:0] active_dp;
  logic [VW-1:0]      shadow_val;
  logic [NDIGITS-1:0] shadow_dp;
  logic               pending;
  logic               pending_next;

  logic               slot_end;
  logic               frame_end;
  logic               accept;

  logic [3:0]         act_nib [NDIGITS];
  logic [NDIGITS-1:0] zero_from;
  logic               blank_digit;
  logic [3:0]         cur_nib;
  logic [6:0]         cur_seg;

  logic [NDIGITS-1:0] ct_d;
  logic [7:0]         leds_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign accept    = load_valid && load_ready;

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BLANK;
    else       state <= next_state;
  end

  // Scan FSM next state: BLANK for the first BLANK_CYCLES of a slot, then SHOW.
  always_comb begin
    next_state = state;
    case (state)
      BLANK: if (cnt == BLANK_LAST) next_state = SHOW;
      SHOW:  if (slot_end)          next_state = BLANK;
      default: next_state = BLANK;
    endcase
  end

  // A pending load is consumed at the frame boundary; a new load can only be
  // accepted while nothing is pending, so the two never coincide.
  always_comb begin
    pending_next = pending;
    if (frame_end && pending) pending_next = 1'b0;
    else if (accept)          pending_next = 1'b1;
  end

  // Shadow capture and frame-aligned transfer to the active word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      if (accept) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end
      if (frame_end && pending) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      pending    <= pending_next;
      load_ready <= ~pending_next;
    end
  end

  // Split the active word into nibbles.
  always_comb begin
    for (int i = 0; i < NDIGITS; i++) act_nib[i] = active_val[4*i +: 4];
  end

  // zero_from[i] is set when active nibbles i..NDIGITS-1 are all zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    zero_from = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (act_nib[i] == 4'h0);
      zero_from[i] = all_zero;
    end
  end

  assign blank_digit = lzb_en && (idx != '0) && zero_from[idx];
  assign cur_nib     = act_nib[idx];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg_c  (cur_seg)
  );

  // Output decode from the current state; registered below.
  always_comb begin
    ct_d   = '0;
    leds_d = SEG_OFF;
    if ((state == SHOW) && !blank_digit) begin
      ct_d   = NDIGITS'(digit_onehot(3'(idx)));
      leds_d = {~active_dp[idx], cur_seg};
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct         <= '0;
      leds       <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      ct         <= ct_d;
      leds       <= leds_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// Stimulus pushes hand-computed per-frame expectations tagged with the frame
// number they belong to; the monitor pops an entry when that frame starts
// (frame_done) and samples each digit slot's blank and shown phases.
module tb_seg7_scan_ctrl;

  localparam int unsigned NDIGITS      = 4;
  localparam int unsigned PRESCALE     = 8;
  localparam int unsigned BLANK_CYCLES = 2;

  localparam logic [15:0] CT_ALL = 16'h8421;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic        lzb_en;
  logic [7:0]  leds;
  logic [3:0]  ct;
  logic        frame_done;

  typedef struct {
    int                frame;
    logic [3:0][3:0]   ct;
    logic [3:0][7:0]   leds;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int frame_no = 0;

  seg7_scan_ctrl #(
    .NDIGITS      (NDIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .lzb_en     (lzb_en),
    .leds       (leds),
    .ct         (ct),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input int frame, input logic [15:0] ctv, input logic [31:0] ledv);
    exp_frame_t e;
    e.frame = frame;
    e.ct    = ctv;
    e.leds  = ledv;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the next frame_done; prev_ready is load_ready on the cycle before it.
  task automatic wait_fd(output logic prev_ready);
    bit ok;
    ok = 1'b0;
    prev_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      prev_ready = load_ready;
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("frame_done_timeout", 32'(frame_done), 32'(1));
  endtask

  task automatic goto_offset(input int k);
    logic pr;
    wait_fd(pr);
    repeat (k) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input string name);
    load_valid = 1'b1;
    value_in   = v;
    dp_in      = dp;
    @(negedge clk);
    load_valid = 1'b0;
    chk({name, "_ready_drop"}, 32'(load_ready), 32'(0));
  endtask

  // Monitor: checks every tagged frame, slot by slot.
  initial begin
    exp_frame_t e;
    logic fd_now;
    int slot, ph;
    forever begin
      @(negedge clk);
      fd_now = frame_done;
      while (fd_now === 1'b1) begin
        fd_now = 1'b0;
        frame_no++;
        while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
          e = exp_q.pop_front();
          chk("frame_missed", 32'(frame_no), 32'(e.frame));
        end
        if (exp_q.size() > 0 && exp_q[0].frame == frame_no) begin
          e = exp_q.pop_front();
          for (int off = 1; off <= 29; off++) begin
            @(negedge clk);
            slot = (off - 1) / 8;
            ph   = (off - 1) % 8;
            if (ph == 1) begin
              chk($sformatf("f%0d_s%0d_blank_ct", frame_no, slot), 32'(ct), 32'(0));
              chk($sformatf("f%0d_s%0d_blank_leds", frame_no, slot), 32'(leds), 32'hFF);
            end else if (ph == 4) begin
              chk($sformatf("f%0d_s%0d_ct", frame_no, slot), 32'(ct), 32'(e.ct[slot]));
              chk($sformatf("f%0d_s%0d_leds", frame_no, slot), 32'(leds), 32'(e.leds[slot]));
            end
          end
          repeat (3) @(negedge clk);
          chk($sformatf("f%0d_period", frame_no), 32'(frame_done), 32'(1));
          fd_now = frame_done;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  // Stimulus.
  initial begin
    logic pr;
    int   base;
    rst        = 1'b1;
    load_valid = 1'b0;
    value_in   = '0;
    dp_in      = '0;
    lzb_en     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'hFF);
    chk("rst_ct", 32'(ct), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_ready", 32'(load_ready), 32'(1));
    rst = 1'b0;
    push_exp(1, CT_ALL, 32'hC0C0C0C0);

    // 1234, no dp, no blanking
    goto_offset(10);
    load(16'h1234, 4'b0000, "t1");
    push_exp(frame_no + 1, CT_ALL, 32'hF9A4B099);

    // 00A0 with leading-zero blanking, then without
    goto_offset(10);
    lzb_en = 1'b1;
    load(16'h00A0, 4'b0000, "t2");
    push_exp(frame_no + 1, 16'h0021, 32'hFFFF88C0);
    goto_offset(30);
    lzb_en = 1'b0;
    push_exp(frame_no + 1, CT_ALL, 32'hC0C088C0);

    // 8888 with dp on digit 2
    goto_offset(10);
    load(16'h8888, 4'b0100, "t3");
    push_exp(frame_no + 1, CT_ALL, 32'h80008080);

    // mid-frame load, second valid while not ready is ignored
    goto_offset(10);
    load_valid = 1'b1;
    value_in   = 16'h7C3E;
    dp_in      = 4'b0000;
    @(negedge clk);
    chk("t4_ready_drop", 32'(load_ready), 32'(0));
    value_in = 16'hFFFF;
    dp_in    = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("t4_ready_held_low", 32'(load_ready), 32'(0));
    end
    load_valid = 1'b0;
    push_exp(frame_no + 1, CT_ALL, 32'hF8C6B086);
    push_exp(frame_no + 2, CT_ALL, 32'hF8C6B086);
    wait_fd(pr);
    chk("t4_ready_at_boundary", 32'(pr), 32'(0));
    chk("t4_ready_after_boundary", 32'(load_ready), 32'(1));

    // load accepted on the boundary cycle itself
    repeat (31) @(negedge clk);
    base       = frame_no;
    load_valid = 1'b1;
    value_in   = 16'h0B6D;
    dp_in      = 4'b0000;
    @(negedge clk);
    load_valid = 1'b0;
    chk("t5_frame_done", 32'(frame_done), 32'(1));
    chk("t5_ready_drop", 32'(load_ready), 32'(0));
    push_exp(base + 2, CT_ALL, 32'hC08382A1);
    wait_fd(pr);
    chk("t5_ready_at_boundary", 32'(pr), 32'(0));
    chk("t5_ready_after_boundary", 32'(load_ready), 32'(1));

    // reset during digit 2 SHOW
    goto_offset(21);
    chk("t6_pre_ct", 32'(ct), 32'(4'b0100));
    chk("t6_pre_leds", 32'(leds), 32'h83);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_ct", 32'(ct), 32'(0));
    chk("t6_async_leds", 32'(leds), 32'hFF);
    chk("t6_async_frame_done", 32'(frame_done), 32'(0));
    chk("t6_async_ready", 32'(load_ready), 32'(1));
    @(negedge clk);
    rst  = 1'b0;
    base = frame_no;
    push_exp(base + 1, CT_ALL, 32'hC0C0C0C0);
    @(negedge clk);
    chk("t6_c1_ct", 32'(ct), 32'(0));
    @(negedge clk);
    chk("t6_c2_ct", 32'(ct), 32'(0));
    @(negedge clk);
    chk("t6_c3_ct", 32'(ct), 32'(4'b0001));
    chk("t6_c3_leds", 32'(leds), 32'hC0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
